// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] ALUControl;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder,
// NZCV flag register and condition-field evaluation.
module multicycle_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input logic             clk,
  input logic             reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB,
    MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state, next;

  logic [1:0] nz, cv;
  logic       cond_r;
  logic       cond_ex;

  logic       next_pc, reg_w, mem_w;
  logic       branch, alu_op;
  logic       adr_src;
  logic [1:0] src_a, src_b, res_src;

  logic [3:0] cmd;
  logic       cmd_ok;
  logic [1:0] dp_ctl;
  logic       flag_w_nz, flag_w_cv;
  logic       rd_pc, pcs;

  assign cmd = bus.Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next    = state;
    next_pc = 1'b0;
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    branch  = 1'b0;
    alu_op  = 1'b0;
    adr_src = 1'b0;
    src_a   = 2'b00;
    src_b   = 2'b00;
    res_src = 2'b00;
    unique case (state)
      FETCH: begin
        next    = DECODE;
        next_pc = 1'b1;
        src_a   = 2'b01;
        src_b   = 2'b10;
        res_src = 2'b10;
      end
      DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        res_src = 2'b10;
        unique case (bus.Op)
          2'b00:   next = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   next = MEMADR;
          2'b10:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        src_b = 2'b01;
        next  = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        next    = MEMWB;
      end
      MEMWB: begin
        res_src = 2'b01;
        reg_w   = 1'b1;
        next    = FETCH;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        next    = FETCH;
      end
      EXECR: begin
        alu_op = 1'b1;
        next   = ALUWB;
      end
      EXECI: begin
        src_b  = 2'b01;
        alu_op = 1'b1;
        next   = ALUWB;
      end
      ALUWB: begin
        // unsupported DP commands retire as no-ops
        reg_w = cmd_ok;
        next  = FETCH;
      end
      BRANCH: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        res_src = 2'b10;
        branch  = 1'b1;
        next    = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  always_comb begin
    dp_ctl = 2'b00;
    cmd_ok = 1'b1;
    case (cmd)
      4'b0100: dp_ctl = 2'b00;
      4'b0010: dp_ctl = 2'b01;
      4'b0000: dp_ctl = 2'b10;
      4'b1100: dp_ctl = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  assign flag_w_nz = alu_op & bus.Funct[0] & cmd_ok;
  assign flag_w_cv = flag_w_nz &
                     (cmd == 4'b0100 | cmd == 4'b0010);

  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = nz[0];
      4'b0001: cond_ex = ~nz[0];
      4'b0010: cond_ex = cv[1];
      4'b0011: cond_ex = ~cv[1];
      4'b0100: cond_ex = nz[1];
      4'b0101: cond_ex = ~nz[1];
      4'b0110: cond_ex = cv[0];
      4'b0111: cond_ex = ~cv[0];
      4'b1000: cond_ex = cv[1] & ~nz[0];
      4'b1001: cond_ex = ~(cv[1] & ~nz[0]);
      4'b1010: cond_ex = nz[1] == cv[0];
      4'b1011: cond_ex = nz[1] != cv[0];
      4'b1100: cond_ex = ~nz[0] & (nz[1] == cv[0]);
      4'b1101: cond_ex = ~(~nz[0] & (nz[1] == cv[0]));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nz     <= FLAGS_RST[3:2];
      cv     <= FLAGS_RST[1:0];
      cond_r <= 1'b0;
    end else begin
      if (state == DECODE) cond_r <= cond_ex;
      if (flag_w_nz & cond_r) nz <= bus.ALUFlags[3:2];
      if (flag_w_cv & cond_r) cv <= bus.ALUFlags[1:0];
    end
  end

  assign rd_pc = bus.Rd == 4'd15;
  assign pcs   = branch | (reg_w & rd_pc);

  assign bus.PCWrite    = next_pc | (pcs & cond_r);
  assign bus.MemWrite   = mem_w & cond_r;
  assign bus.RegWrite   = reg_w & cond_r & ~rd_pc;
  assign bus.IRWrite    = next_pc;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ImmSrc     = bus.Op;
  assign bus.ALUControl = alu_op ? dp_ctl : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against an instruction-level model,
// plus directed literal checks for flags, conditions and reset.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.FLAGS_RST(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int P_F   = 0;
  localparam int P_D   = 1;
  localparam int P_MA  = 2;
  localparam int P_MR  = 3;
  localparam int P_MWB = 4;
  localparam int P_MW  = 5;
  localparam int P_XR  = 6;
  localparam int P_XI  = 7;
  localparam int P_AWB = 8;
  localparam int P_BR  = 9;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0]  m_nzcv = 4'b0000;
  logic        m_condr = 1'b0;
  logic [16:0] exp_vec = '0;
  logic        exp_valid = 1'b0;
  logic [16:0] rec [0:4];
  logic [16:0] act;

  assign act = {bus.PCWrite, bus.MemWrite, bus.RegWrite,
                bus.IRWrite, bus.AdrSrc, bus.RegSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                bus.ImmSrc, bus.ALUControl};

  always @(negedge clk) begin
    cyc++;
    if (exp_valid) begin
      checks++;
      if (act !== exp_vec) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%05h want=%05h",
                 cyc, act, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ARM rule: even codes test a predicate, the next odd code its inverse
  function automatic logic cond_holds(input logic [3:0] c,
                                      input logic [3:0] f);
    logic n, z, k, v, r;
    {n, z, k, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = k;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = k && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return c[0] ? !r : r;
  endfunction

  function automatic logic cmd_ok(input logic [3:0] cmd);
    return cmd == 4'd4 || cmd == 4'd2 ||
           cmd == 4'd0 || cmd == 4'd12;
  endfunction

  function automatic logic [16:0] model_out(
      input int ph, input logic [1:0] op, input logic [5:0] fn,
      input logic [3:0] rd, input logic cx);
    logic irw, regw, memw, br, aluop, adr, pcw;
    logic [1:0] a, b, res, ctl;
    logic [3:0] cmd;
    cmd = fn[4:1];
    irw = 0; regw = 0; memw = 0; br = 0;
    aluop = 0; adr = 0; a = 0; b = 0; res = 0;
    case (ph)
      P_F:   begin irw = 1; a = 1; b = 2; res = 2; end
      P_D:   begin a = 1; b = 2; res = 2; end
      P_MA:  b = 1;
      P_MR:  adr = 1;
      P_MWB: begin res = 1; regw = 1; end
      P_MW:  begin adr = 1; memw = 1; end
      P_XR:  aluop = 1;
      P_XI:  begin aluop = 1; b = 1; end
      P_AWB: regw = cmd_ok(cmd);
      default: begin a = 2; b = 1; res = 2; br = 1; end
    endcase
    if (!aluop)            ctl = 2'd0;
    else if (cmd == 4'd2)  ctl = 2'd1;
    else if (cmd == 4'd0)  ctl = 2'd2;
    else if (cmd == 4'd12) ctl = 2'd3;
    else                   ctl = 2'd0;
    pcw = irw || ((br || (regw && rd == 4'd15)) && cx);
    return {pcw, memw && cx, regw && cx && rd != 4'd15, irw, adr,
            op == 2'b01, op == 2'b10, a, b, res, op, ctl};
  endfunction

  task automatic run_instr(
      input logic [3:0] c, input logic [1:0] op,
      input logic [5:0] fn, input logic [3:0] rd,
      input logic [3:0] fl, input bit rand_fl, input int rst_at);
    int ph[5];
    int n;
    logic [3:0] f;
    ph[0] = P_F;
    ph[1] = P_D;
    ph[2] = P_F;
    ph[3] = P_F;
    ph[4] = P_F;
    case (op)
      2'b00: begin ph[2] = fn[5] ? P_XI : P_XR; ph[3] = P_AWB; n = 4; end
      2'b01: begin
        ph[2] = P_MA;
        if (fn[0]) begin ph[3] = P_MR; ph[4] = P_MWB; n = 5; end
        else begin ph[3] = P_MW; n = 4; end
      end
      2'b10: begin ph[2] = P_BR; n = 3; end
      default: n = 2;
    endcase
    for (int p = 0; p < 5; p++) rec[p] = '0;
    for (int p = 0; p < n; p++) begin
      f = rand_fl ? 4'($urandom) : fl;
      bus.Cond = c;
      bus.Op = op;
      bus.Funct = fn;
      bus.Rd = rd;
      bus.ALUFlags = f;
      exp_vec = model_out(ph[p], op, fn, rd, m_condr);
      exp_valid = 1'b1;
      if (p == rst_at) reset = 1'b1;
      if (ph[p] == P_D) m_condr = cond_holds(c, m_nzcv);
      if ((ph[p] == P_XR || ph[p] == P_XI) && m_condr &&
          fn[0] && cmd_ok(fn[4:1])) begin
        m_nzcv[3:2] = f[3:2];
        if (fn[4:1] == 4'd4 || fn[4:1] == 4'd2) m_nzcv[1:0] = f[1:0];
      end
      @(negedge clk);
      rec[p] = act;
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        m_nzcv = 4'b0000;
        m_condr = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    bus.Cond = 4'hE;
    bus.Op = 2'b00;
    bus.Funct = '0;
    bus.Rd = '0;
    bus.ALUFlags = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_irwrite", {3'b0, bus.IRWrite}, 4'd1);
    chk("rst_pcwrite", {3'b0, bus.PCWrite}, 4'd1);

    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0, 0, -1);
    chk("add_ctl_exec", {2'b0, rec[2][1:0]}, 4'd0);
    chk("add_regw_exec", {3'b0, rec[2][14]}, 4'd0);
    chk("add_regw_wb", {3'b0, rec[3][14]}, 4'd1);

    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 0, -1);
    chk("ldr_adrsrc", {3'b0, rec[3][12]}, 4'd1);
    chk("ldr_wb_regw", {3'b0, rec[4][14]}, 4'd1);
    chk("ldr_wb_res", {2'b0, rec[4][5:4]}, 4'd1);
    chk("ldr_memw", {3'b0, rec[0][15] | rec[1][15] | rec[2][15] |
                           rec[3][15] | rec[4][15]}, 4'd0);

    run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 0, -1);
    chk("str_memw", {3'b0, rec[3][15]}, 4'd1);
    chk("str_adrsrc", {3'b0, rec[3][12]}, 4'd1);
    chk("str_regw", {3'b0, rec[2][14] | rec[3][14]}, 4'd0);

    run_instr(4'hE, 2'b00, 6'b000101, 4'd4, 4'b0100, 0, -1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 0, -1);
    chk("beq_taken", {3'b0, rec[2][16]}, 4'd1);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, 0, -1);
    chk("bne_not_taken", {3'b0, rec[2][16]}, 4'd0);

    run_instr(4'h0, 2'b00, 6'b001000, 4'd15, 4'h0, 0, -1);
    chk("addeq_pc_z1_pcw", {3'b0, rec[3][16]}, 4'd1);
    chk("addeq_pc_z1_regw", {3'b0, rec[3][14]}, 4'd0);
    run_instr(4'hE, 2'b00, 6'b000101, 4'd4, 4'b0000, 0, -1);
    run_instr(4'h0, 2'b00, 6'b001000, 4'd15, 4'h0, 0, -1);
    chk("addeq_pc_z0_pcw", {3'b0, rec[3][16]}, 4'd0);
    chk("addeq_pc_z0_regw", {3'b0, rec[3][14]}, 4'd0);

    run_instr(4'hE, 2'b00, 6'b000101, 4'd4, 4'b0100, 0, -1);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd5, 4'h0, 0, 3);
    chk("abort_memrd_adr", {3'b0, rec[3][12]}, 4'd1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 0, -1);
    chk("post_rst_irwrite", {3'b0, rec[0][13]}, 4'd1);
    chk("post_rst_regw", {3'b0, rec[0][14]}, 4'd0);
    chk("post_rst_z_clear", {3'b0, rec[2][16]}, 4'd0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] c, rd, cmd;
      logic [1:0] op;
      logic [5:0] fn;
      int ra;
      c = ($urandom % 2 == 0) ? 4'hE : 4'($urandom);
      op = 2'($urandom);
      fn = 6'($urandom);
      if (op == 2'b00 && $urandom % 5 != 0) begin
        case ($urandom % 4)
          0: cmd = 4'd4;
          1: cmd = 4'd2;
          2: cmd = 4'd0;
          default: cmd = 4'd12;
        endcase
        fn[4:1] = cmd;
      end
      rd = ($urandom % 6 == 0) ? 4'd15 : 4'($urandom);
      ra = ($urandom % 25 == 0) ? int'($urandom % 5) : -1;
      run_instr(c, op, fn, rd, 4'h0, 1'b1, ra);
    end

    exp_valid = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
